// File: rtl/receiver_axis_pkg.sv
// Shared types and constants for the buffered UART-to-AXI-Stream receiver.
package receiver_axis_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_DATA       = 3'd2,
        ST_PARITY     = 3'd3,
        ST_STOP       = 3'd4,
        ST_BREAK_WAIT = 3'd5
    } rx_state_e;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    localparam int unsigned TUSER_PARITY_ERR  = 0;
    localparam int unsigned TUSER_FRAMING_ERR = 1;

    // odd_mode=1: data plus parity bit must hold an odd number of ones.
    function automatic logic parity_error(input logic odd_mode, input logic data_xor,
                                          input logic par_bit);
        return (data_xor ^ par_bit) != odd_mode;
    endfunction

endpackage

// File: rtl/axis_fifo.sv
// Synchronous word FIFO with AXI-Stream style read side and drop-on-full write side.
module axis_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             drop,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             full, empty, pop, wr_en;

    always_comb begin
        empty     = (wr_ptr_q == rd_ptr_q);
        full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop_valid = !empty && !rst;
        pop       = pop_valid && pop_ready;
        // A pop in the same cycle frees the slot being written.
        wr_en     = push && !rst && (!full || pop);
        drop      = push && !rst && full && !pop;
        pop_data  = pop_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
        wr_ptr_d  = wr_ptr_q + (AW+1)'(wr_en);
        rd_ptr_d  = rd_ptr_q + (AW+1)'(pop);
        mem_d     = mem_q;
        if (wr_en) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/receiver_axis_buffered.sv
// UART receiver feeding an AXI-Stream word FIFO with per-word parity/framing flags.
// Define RECEIVER_AXIS_SYNC_EN to add a 2-flop synchronizer on din (+2 cycles latency).
module receiver_axis_buffered
    import receiver_axis_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 32'd100_000_000,
    parameter int unsigned BAUD_RATE       = 32'd115200,
    parameter int unsigned WORD_WIDTH      = 32'd8,
    parameter int unsigned PARITY          = 0,
    parameter int unsigned STOP_BITS       = 1,
    parameter int unsigned FIFO_DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  din,
    output logic [WORD_WIDTH-1:0] dout_axis_tdata,
    output logic [1:0]            dout_axis_tuser,
    output logic                  dout_axis_tvalid,
    input  logic                  dout_axis_tready,
    output logic                  overrun
);

    localparam int unsigned P    = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int unsigned HALF = P / 2;
    localparam int unsigned CW   = $clog2(P + 1);
    localparam int unsigned FW   = WORD_WIDTH + 2;

    logic din_s;

`ifdef RECEIVER_AXIS_SYNC_EN
    logic [1:0] sync_q, sync_d;
    always_comb sync_d = {sync_q[0], din};
    always_ff @(posedge clk) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= sync_d;
    end
    assign din_s = sync_q[1];
`else
    assign din_s = din;
`endif

    rx_state_e             state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [3:0]            bit_q, bit_d;
    logic [WORD_WIDTH-1:0] data_q, data_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  armed_q, armed_d;
    logic                  push, tick;
    logic [FW-1:0]         push_data, pop_data;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        data_d  = data_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        armed_d = armed_q;
        push    = 1'b0;
        tick    = (cnt_q == CW'(P));
        case (state_q)
            ST_IDLE: begin
                // First idle cycle after reset: a low line is a break, not a start bit.
                if (!armed_q) begin
                    armed_d = 1'b1;
                    if (!din_s) state_d = ST_BREAK_WAIT;
                end else if (!din_s) begin
                    state_d = ST_START;
                    cnt_d   = CW'(1);
                end
            end
            ST_START: begin
                if (cnt_q == CW'(HALF)) begin
                    if (din_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                        cnt_d   = CW'(1);
                        bit_d   = '0;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (tick) begin
                    cnt_d  = CW'(1);
                    data_d = {din_s, data_q[WORD_WIDTH-1:1]};
                    if (bit_q == 4'(WORD_WIDTH - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY == PARITY_NONE) ? ST_STOP : ST_PARITY;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    cnt_d   = CW'(1);
                    perr_d  = parity_error(PARITY == PARITY_ODD, ^data_q, din_s);
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (tick) begin
                    cnt_d  = CW'(1);
                    ferr_d = ferr_q | !din_s;
                    if (bit_q == 4'(STOP_BITS - 1)) begin
                        push    = 1'b1;
                        state_d = ferr_d ? ST_BREAK_WAIT : ST_IDLE;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_BREAK_WAIT: begin
                if (din_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        push_data                                = '0;
        push_data[WORD_WIDTH-1:0]                = data_q;
        push_data[WORD_WIDTH+TUSER_PARITY_ERR]   = perr_q;
        push_data[WORD_WIDTH+TUSER_FRAMING_ERR]  = ferr_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            armed_q <= armed_d;
        end
    end

    axis_fifo #(
        .WIDTH(FW),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(push_data),
        .drop     (overrun),
        .pop_valid(dout_axis_tvalid),
        .pop_ready(dout_axis_tready),
        .pop_data (pop_data)
    );

    assign dout_axis_tdata = pop_data[WORD_WIDTH-1:0];
    assign dout_axis_tuser = pop_data[FW-1:WORD_WIDTH];

endmodule
